// File: rtl/fourbc_pkg.sv
// Shared state encoding and default widths for the 4-bit counter sequencer.
package fourbc_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  localparam int FOURBC_W      = 4;
  localparam int FOURBC_PASS_W = 4;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

endpackage

// File: rtl/fourbc_seq_ctrl_sync_count4.sv
// Synchronous up-counter with clear; clr wins over en, wraps naturally at all-ones.
module sync_count4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d;

  always_comb begin
    q_d = q_q;
    if (clr)
      q_d = '0;
    else if (en)
      q_d = q_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) q_q <= '0;
    else       q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/fourbc_seq_ctrl.sv
// Sequencer sweeping the counter 0..target for a latched number of passes.
//   state  | meaning
//   IDLE   | waiting for start; q held at 0
//   RUN    | counter advancing while pause is low
//   DONE   | one-cycle completion pulse, then back to IDLE
module fourbc_seq_ctrl
  import fourbc_pkg::*;
#(
  parameter int WIDTH  = FOURBC_W,
  parameter int PASS_W = FOURBC_PASS_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WIDTH-1:0]  target,
  input  logic [PASS_W-1:0] passes,
  input  logic              pause,
  input  logic              abort,
  output logic              t_en,
  output logic [WIDTH-1:0]  q,
  output logic [PASS_W-1:0] pass_cnt,
  output logic              busy,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  tgt_q, tgt_d;
  logic [PASS_W-1:0] npass_q, npass_d;
  logic [PASS_W-1:0] pass_cnt_q, pass_cnt_d;
  logic [PASS_W-1:0] pass_inc;
  logic              t_en_q, t_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              cnt_en, cnt_clr;

  assign pass_inc = pass_cnt_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    tgt_d      = tgt_q;
    npass_d    = npass_q;
    pass_cnt_d = pass_cnt_q;
    cnt_en     = 1'b0;
    cnt_clr    = 1'b0;
    err_d      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!abort && start) begin
          if (target != '0 && passes != '0) begin
            tgt_d      = target;
            npass_d    = passes;
            pass_cnt_d = '0;
            cnt_clr    = 1'b1;
            state_d    = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (abort) begin
          pass_cnt_d = '0;
          cnt_clr    = 1'b1;
          state_d    = S_IDLE;
        end else if (!pause) begin
          // terminal edge restarts the sweep at 0 and books the pass
          if (q == tgt_q) begin
            cnt_clr    = 1'b1;
            pass_cnt_d = pass_inc;
            if (pass_inc == npass_q)
              state_d = S_DONE;
          end else begin
            cnt_en = 1'b1;
          end
        end
      end
      S_DONE: begin
        if (abort)
          pass_cnt_d = '0;
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        cnt_clr = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    t_en_d = (state_d == S_RUN) && !pause;
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tgt_q      <= '0;
      npass_q    <= '0;
      pass_cnt_q <= '0;
      t_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tgt_q      <= tgt_d;
      npass_q    <= npass_d;
      pass_cnt_q <= pass_cnt_d;
      t_en_q     <= t_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  sync_count4 #(.WIDTH(WIDTH)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .en    (cnt_en),
    .clr   (cnt_clr),
    .q     (q)
  );

  assign t_en     = t_en_q;
  assign pass_cnt = pass_cnt_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule
